// File: rtl/life_readout.sv
// life_readout
//   Takes a snapshot of a life-cell output shift chain and sends it to the host
//   as packed words on a valid/ready stream. One instance serves one chain.
//
//   A readout runs as follows:
//     1. A one-cycle load_out pulse copies every cell's state into its out_data
//        register.
//     2. The block drives shift to walk the chain past its tail, one bit per
//        enabled cycle. The bits are packed LSB-first into WORD_W-bit words.
//     3. Each word is presented on m_valid/m_data/m_last until the host takes it.
//
//   Parameters
//     CHAIN_LEN  number of cells in the chain (>= 2)
//     WORD_W     output word width (1 .. CHAIN_LEN)
//
//   Ports
//     clk         clock; all logic updates on the rising edge
//     reset       synchronous, active-high reset (the cells share it)
//     start       requests one full readout; only sampled in IDLE
//     chain_data  out_data of the tail cell
//     load_out    to all cells: copy state into out_data
//     shift       to all cells: out_data <= previous cell's out_data
//     busy        high from the cycle after start is accepted until done
//     done        one-cycle pulse after the final word has been accepted
//     m_valid     output word valid
//     m_data      output word; the first chain bit is in the LSB
//     m_last      marks the final word of a readout
//     m_ready     the host accepts the word when m_valid && m_ready
//
//   Optional build macro LIFE_READOUT_POPCOUNT_EN
//     Adds the output live_count, which counts the 1-bits sampled in a readout.
//     It is cleared when a readout starts and holds its final value from done
//     until the next readout.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for start; done pulses here after a readout
//   ST_LOAD  | one cycle with load_out=1 so the cells take their snapshot
//   ST_SHIFT | sample chain_data into the assembly register and advance chain
//   ST_DRAIN | all bits taken; wait for the final word to be accepted
module life_readout #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              chain_data,
  output logic              load_out,
  output logic              shift,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
`ifdef LIFE_READOUT_POPCOUNT_EN
  ,
  output logic [$clog2(CHAIN_LEN+1)-1:0] live_count
`endif
);

  localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BIT_W   = $clog2(CHAIN_LEN);
  localparam int POS_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WIDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(WORD_W - 1);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(N_WORDS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]        state;
  logic [BIT_W-1:0]  bit_idx;   // position along the chain
  logic [POS_W-1:0]  bit_pos;   // position inside the current word
  logic [WIDX_W-1:0] word_idx;  // index of the word being assembled
  logic [WORD_W-1:0] asm_reg;
  logic [WORD_W-1:0] asm_next;
  logic              last_bit;
  logic              word_done;
  logic              sample_en;

  always_comb begin
    last_bit  = (bit_idx == LAST_BIT);
    word_done = last_bit || (bit_pos == LAST_POS);
    // If the word completing this cycle has nowhere to go (the output register
    // is still full), the whole step stalls. The chain is not shifted either,
    // so the same tail bit is sampled again once the host drains the register.
    sample_en = (state == ST_SHIFT) && !(word_done && m_valid && !m_ready);
    asm_next          = asm_reg;
    asm_next[bit_pos] = chain_data;
  end

  assign load_out = (state == ST_LOAD);
  // The last bit is already at the tail, so no shift is needed after it. That
  // gives CHAIN_LEN-1 shifts per readout.
  assign shift    = sample_en && !last_bit;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      bit_pos  <= '0;
      word_idx <= '0;
      asm_reg  <= '0;
      done     <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          state    <= ST_SHIFT;
          bit_idx  <= '0;
          bit_pos  <= '0;
          word_idx <= '0;
          asm_reg  <= '0;
        end

        ST_SHIFT: begin
          if (sample_en) begin
            if (word_done) begin
              asm_reg  <= '0;
              bit_pos  <= '0;
              word_idx <= word_idx + 1'b1;
            end else begin
              asm_reg <= asm_next;
              bit_pos <= bit_pos + 1'b1;
            end

            if (last_bit) begin
              state    <= ST_DRAIN;
              bit_idx  <= '0;
              word_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          // Only the final word can still be held here. Earlier words had to
          // be accepted before the final word could be loaded.
          if (m_valid && m_ready) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // A word is loaded on the same edge that samples its closing bit. The
      // stall condition above ensures this never overwrites a word that has
      // not been accepted.
      if (sample_en && word_done) begin
        m_data  <= asm_next;
        m_valid <= 1'b1;
        m_last  <= (word_idx == LAST_WORD);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

`ifdef LIFE_READOUT_POPCOUNT_EN
  // Cleared when start is accepted, so the count already reads 0 during LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_count <= '0;
    end else if (state == ST_IDLE && start) begin
      live_count <= '0;
    end else if (sample_en && chain_data) begin
      live_count <= live_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_life_readout.sv
module tb_life_readout;

  localparam int LA  = 16;
  localparam int WA  = 8;
  localparam int NWA = (LA + WA - 1) / WA;
  localparam int LB  = 10;
  localparam int WB  = 4;
  localparam int NWB = (LB + WB - 1) / WB;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          start_a, chain_a, load_a, shift_a, busy_a, done_a, mv_a, ml_a, mr_a;
  logic [WA-1:0] md_a;
  logic          start_b, chain_b, load_b, shift_b, busy_b, done_b, mv_b, ml_b, mr_b;
  logic [WB-1:0] md_b;
`ifdef LIFE_READOUT_POPCOUNT_EN
  logic [$clog2(LA+1)-1:0] live_a;
  logic [$clog2(LB+1)-1:0] live_b;
`endif

  life_readout #(.CHAIN_LEN(LA), .WORD_W(WA)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .chain_data(chain_a),
    .load_out(load_a), .shift(shift_a), .busy(busy_a), .done(done_a),
    .m_valid(mv_a), .m_data(md_a), .m_last(ml_a), .m_ready(mr_a)
`ifdef LIFE_READOUT_POPCOUNT_EN
    , .live_count(live_a)
`endif
  );

  life_readout #(.CHAIN_LEN(LB), .WORD_W(WB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .chain_data(chain_b),
    .load_out(load_b), .shift(shift_b), .busy(busy_b), .done(done_b),
    .m_valid(mv_b), .m_data(md_b), .m_last(ml_b), .m_ready(mr_b)
`ifdef LIFE_READOUT_POPCOUNT_EN
    , .live_count(live_b)
`endif
  );

  // Cell chain models: snap[0] is the tail, and a shift moves every bit one
  // place toward the tail.
  logic [LA-1:0] pat_a, snap_a;
  logic [LB-1:0] pat_b, snap_b;

  always @(posedge clk) begin
    if (reset) begin
      snap_a <= '0;
      snap_b <= '0;
    end else begin
      if (load_a)       snap_a <= pat_a;
      else if (shift_a) snap_a <= snap_a >> 1;
      if (load_b)       snap_b <= pat_b;
      else if (shift_b) snap_b <= snap_b >> 1;
    end
  end
  assign chain_a = snap_a[0];
  assign chain_b = snap_b[0];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  exp_t exp_a[$];
  exp_t exp_b[$];

  task automatic push_a(input logic [LA-1:0] p);
    exp_t e;
    for (int w = 0; w < NWA; w++) begin
      e.data = '0;
      for (int b = 0; b < WA; b++)
        if (w * WA + b < LA) e.data[b] = p[w*WA+b];
      e.last = (w == NWA - 1);
      exp_a.push_back(e);
    end
  endtask

  task automatic push_b(input logic [LB-1:0] p);
    exp_t e;
    for (int w = 0; w < NWB; w++) begin
      e.data = '0;
      for (int b = 0; b < WB; b++)
        if (w * WB + b < LB) e.data[b] = p[w*WB+b];
      e.last = (w == NWB - 1);
      exp_b.push_back(e);
    end
  endtask

  int n_load_a = 0, n_shift_a = 0, n_done_a = 0;
  int n_load_b = 0, n_shift_b = 0, n_done_b = 0;

  // Monitor: counts pulses, checks held words against the queue head, and
  // pops and compares a word on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (load_a)  n_load_a++;
      if (shift_a) n_shift_a++;
      if (done_a)  n_done_a++;
      if (load_b)  n_load_b++;
      if (shift_b) n_shift_b++;
      if (done_b)  n_done_b++;

      if (mv_a) begin
        if (exp_a.size() == 0) begin
          check_eq("a_unexpected_word", 32'(md_a), 32'hFFFF_FFFF);
        end else if (mr_a) begin
          e = exp_a.pop_front();
          check_eq("a_word_data", 32'(md_a), e.data);
          check_eq("a_word_last", 32'(ml_a), 32'(e.last));
        end else begin
          check_eq("a_hold_data", 32'(md_a), exp_a[0].data);
        end
      end

      if (mv_b) begin
        if (exp_b.size() == 0) begin
          check_eq("b_unexpected_word", 32'(md_b), 32'hFFFF_FFFF);
        end else if (mr_b) begin
          e = exp_b.pop_front();
          check_eq("b_word_data", 32'(md_b), e.data);
          check_eq("b_word_last", 32'(ml_b), 32'(e.last));
        end else begin
          check_eq("b_hold_data", 32'(md_b), exp_b[0].data);
        end
      end
    end
  end

  task automatic kick_a(input logic [LA-1:0] p);
    pat_a = p;
    push_a(p);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check_eq("a_load_pulse", 32'(load_a), 1);
    check_eq("a_busy", 32'(busy_a), 1);
`ifdef LIFE_READOUT_POPCOUNT_EN
    check_eq("a_popcount_clear", 32'(live_a), 0);
`endif
  endtask

  // Returns in the done cycle. spam holds start high while waiting.
  task automatic wait_done_a(input bit spam, output int cyc);
    cyc = 0;
    while (!done_a && cyc < 400) begin
      start_a = spam;
      @(posedge clk); #1;
      cyc++;
    end
    start_a = 1'b0;
    check_eq("a_done_seen", 32'(done_a), 1);
  endtask

  task automatic kick_b(input logic [LB-1:0] p);
    pat_b = p;
    push_b(p);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check_eq("b_load_pulse", 32'(load_b), 1);
  endtask

  task automatic wait_done_b(output int cyc);
    cyc = 0;
    while (!done_b && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("b_done_seen", 32'(done_b), 1);
  endtask

  localparam logic [LA-1:0] P1 = 16'h8F0D;  // tail-first 1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,1
  localparam logic [LA-1:0] P2 = 16'hA5C3;

  initial begin
    int cyc, s0, l0, d0;
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    mr_a = 1'b1;    mr_b = 1'b1;
    pat_a = '0;     pat_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("a_reset_outputs", 32'({load_a, shift_a, busy_a, done_a, mv_a, ml_a, md_a}), 0);
    check_eq("b_reset_outputs", 32'({load_b, shift_b, busy_b, done_b, mv_b, ml_b, md_b}), 0);
`ifdef LIFE_READOUT_POPCOUNT_EN
    check_eq("a_reset_popcount", 32'(live_a), 0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic readout with the host always ready.
    s0 = n_shift_a; l0 = n_load_a; d0 = n_done_a;
    kick_a(P1);
    wait_done_a(1'b0, cyc);
    check_eq("a_readout_cycles", 32'(cyc), LA + 2);
`ifdef LIFE_READOUT_POPCOUNT_EN
    check_eq("a_popcount_final", 32'(live_a), 8);
`endif
    @(posedge clk); #1;
    check_eq("a_done_one_cycle", 32'(done_a), 0);
    check_eq("a_busy_after", 32'(busy_a), 0);
    check_eq("a_shift_count", 32'(n_shift_a - s0), LA - 1);
    check_eq("a_load_count", 32'(n_load_a - l0), 1);
    check_eq("a_done_count", 32'(n_done_a - d0), 1);

    // Host stalls for 5 cycles when the first word appears.
    s0 = n_shift_a;
    mr_a = 1'b0;
    kick_a(P1);
    cyc = 0;
    while (!mv_a && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check_eq("a_first_valid_cycle", 32'(cyc), WA + 1);
    repeat (5) begin
      check_eq("a_stall_data", 32'(md_a), 32'h0D);
      @(posedge clk); #1;
    end
    check_eq("a_stall_valid", 32'(mv_a), 1);
    mr_a = 1'b1;
    wait_done_a(1'b0, cyc);
    @(posedge clk); #1;
    check_eq("a_stall_shift_count", 32'(n_shift_a - s0), LA - 1);

    // 10-bit chain with 4-bit words, all cells 1.
    s0 = n_shift_b;
    kick_b('1);
    wait_done_b(cyc);
    check_eq("b_readout_cycles", 32'(cyc), LB + 2);
    @(posedge clk); #1;
    check_eq("b_shift_count", 32'(n_shift_b - s0), LB - 1);

    // Second word completes while the first is still held, so the chain must stop.
    s0 = n_shift_b;
    mr_b = 1'b0;
    kick_b(10'b10_0110_1101);
    cyc = 0;
    while (!mv_b && cyc < 100) begin @(posedge clk); #1; cyc++; end
    repeat (6) begin @(posedge clk); #1; end
    check_eq("b_stall_shift_low", 32'(shift_b), 0);
    check_eq("b_stall_shifts_so_far", 32'(n_shift_b - s0), 2 * WB - 1);
    mr_b = 1'b1;
    wait_done_b(cyc);
    @(posedge clk); #1;
    check_eq("b_stall_shift_count", 32'(n_shift_b - s0), LB - 1);

    // Reset after 5 bits of a readout.
    d0 = n_done_a;
    kick_a(P2);
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("a_abort_outputs", 32'({load_a, shift_a, busy_a, done_a, mv_a, ml_a, md_a}), 0);
    reset = 1'b0;
    exp_a.delete();
    repeat (4) begin @(posedge clk); #1; end
    check_eq("a_abort_no_done", 32'(n_done_a - d0), 0);
    check_eq("a_abort_idle", 32'(busy_a), 0);
    s0 = n_shift_a;
    kick_a(P2);
    wait_done_a(1'b0, cyc);
    check_eq("a_after_abort_cycles", 32'(cyc), LA + 2);
    @(posedge clk); #1;
    check_eq("a_after_abort_shifts", 32'(n_shift_a - s0), LA - 1);

    // start held high while busy, then a restart on the done cycle.
    s0 = n_shift_a; l0 = n_load_a; d0 = n_done_a;
    kick_a(P2);
    wait_done_a(1'b1, cyc);
    check_eq("a_spam_load_count", 32'(n_load_a - l0), 1);
    kick_a(P1);
    wait_done_a(1'b0, cyc);
    check_eq("a_restart_cycles", 32'(cyc), LA + 2);
    @(posedge clk); #1;
    check_eq("a_restart_load_count", 32'(n_load_a - l0), 2);
    check_eq("a_restart_done_count", 32'(n_done_a - d0), 2);
    check_eq("a_restart_shift_count", 32'(n_shift_a - s0), 2 * (LA - 1));

    repeat (3) @(posedge clk);
    #1;
    check_eq("a_words_left", 32'(exp_a.size()), 0);
    check_eq("b_words_left", 32'(exp_b.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/life_readout.md
Name: life_readout

Overview:
- Downstream consumer of a life-cell output shift chain: snapshots the grid state and serialises it into words for the host.
- On start, pulses load_out to copy every cell's state into its out_data register.
- Then drives shift to walk the chain past its tail, packs the bits into WORD_W-bit words and emits them on a valid/ready stream with backpressure.
- One instance serves one chain; the top level instantiates one per chain.

Parameters:
CHAIN_LEN, 64, number of cells in the output shift chain (>=2).
WORD_W, 8, output word width in bits (>=1, <=CHAIN_LEN).

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request one full readout; sampled only in IDLE
chain_data  input  1  out_data of the tail cell of the chain
load_out  output  1  to all cells: copy state into out_data
shift  output  1  to all cells: out_data <= prev_out_data
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the last word has been accepted
m_valid  output  1  output word valid
m_data  output  WORD_W  output word; first chain bit in LSB
m_last  output  1  qualifies the final word of a readout
m_ready  input  1  downstream accepts the word when m_valid && m_ready

Behaviour:
- Reset: state IDLE; load_out, shift, busy, done, m_valid, m_last = 0; m_data = 0; bit and word counters = 0; assembly register = 0.
- Reset mid-readout aborts immediately, with no done pulse and no partial word output. The cells are reset by the same signal.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD.
  - LOAD: exactly one cycle; load_out=1; busy=1 -> SHIFT.
  - SHIFT: each enabled cycle samples chain_data into the assembly register at the current bit index. Bit 0 is the tail cell's state.
  - shift=1 on every enabled sample cycle except the one taking bit CHAIN_LEN-1, so there are CHAIN_LEN-1 shifts per readout.
  - After bit CHAIN_LEN-1 -> DRAIN.
  - DRAIN: wait until the final word handshakes -> IDLE, with done=1 in the first IDLE cycle.
- Packing:
  - Bit index i maps to word i/WORD_W, bit i%WORD_W.
  - Word count = ceil(CHAIN_LEN/WORD_W).
  - Unused upper bits of a partial final word are 0.
- A word completes on bit WORD_W-1 of a word or on bit CHAIN_LEN-1.
  - The completed word is written into the output register (m_data, m_valid=1, m_last if final) on the same edge.
  - The assembly register clears on that edge.
- Sample enable (SHIFT state):
  - Disabled when the word completes this cycle && m_valid && !m_ready.
  - When disabled, no sample, shift=0 and counters hold. The chain is not advanced, so no bit is lost.
- Output register:
  - m_valid clears on the handshake unless a new word is loaded the same edge.
  - m_data, m_valid and m_last are stable while m_valid && !m_ready.
- Latency with m_ready=1:
  - start high at cycle 0 -> load_out at cycle 1 -> bit 0 sampled at cycle 2.
  - First m_valid at cycle 2+WORD_W.
  - Total readout is CHAIN_LEN+2 cycles to the final m_valid, and done comes the cycle after its handshake.
- start while busy is ignored.
- start on the done cycle is accepted (IDLE).
- Reads do not disturb the cells' state registers.

Optional Feature:
- Macro LIFE_READOUT_POPCOUNT_EN.
- When defined, adds output live_count [$clog2(CHAIN_LEN+1)-1:0]:
  - Counts sampled 1-bits during SHIFT.
  - Cleared in LOAD.
  - Holds its final value from the done pulse until the next LOAD.
  - Reset value 0.
- When undefined, the port and the counter logic are absent and behaviour is otherwise identical.

Test Plan:
- CHAIN_LEN=16, WORD_W=8, tail-first chain bits 1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,1, m_ready=1 -> m_data 8'h0D then 8'h8F (m_last=1); 15 shift pulses; done pulses once.
- Same config, m_ready=0 for 5 cycles when the first word completes -> shift held low during the stall, m_data=8'h0D stable, no bit lost, second word still 8'h8F.
- CHAIN_LEN=10, WORD_W=4, all cells 1 -> words 4'hF, 4'hF, 4'h3 (m_last on third); 9 shifts total.
- Assert reset during SHIFT after 5 bits -> next cycle all outputs 0, state IDLE, no done; a new start gives a clean full readout.
- start pulsed repeatedly while busy -> exactly one load_out pulse per readout; start on the done cycle begins the next readout.
- LIFE_READOUT_POPCOUNT_EN defined, first pattern -> live_count=8 at done; cleared to 0 in the next LOAD.
